// File: rtl/lpc_postcode_log.sv
// Port-0x80 POST code logger: circular history, stall detect,
// and an index/data read-back window for firmware and debug tools.
module lpc_postcode_log #(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter logic [7:0]  IDX_BASE     = 8'hC0,
  parameter bit          DEDUP        = 1'b1,
  parameter logic [23:0] STALL_CYCLES = 24'd16_500_000
) (
  input  logic                  LPC_CLK,
  input  logic                  LPC_RSTn,
  input  logic                  lpc_en,
  input  logic                  lpc_io_wren,
  input  logic                  lpc_io_rden,
  input  logic                  post_cs,
  input  logic                  data_cs,
  input  logic [7:0]            index,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  dout_en,
  output logic [7:0]            postcode_cur,
  output logic [DEPTH_LOG2:0]   log_count,
  output logic                  overflow,
  output logic                  stalled
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;

  logic       wr, rd;
  logic [7:0] off;
  logic       in_win;
  logic       post_lvl, winw_lvl, winr_lvl;
  logic       post_lvl_q, winw_lvl_q, winr_lvl_q;
  logic       post_wr, win_wr, win_rd_end;
  logic       accept, stat_wr, flush, ovf_clr, pop;
  logic       empty, full;

  ptr_t        rptr_q, rptr_d;
  ptr_t        wptr_q, wptr_d;
  cnt_t        count_q, count_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  cur_q, cur_d;
  logic        seen_q, seen_d;
  logic [23:0] stall_q, stall_d;
  logic [7:0]  mem_q [DEPTH];

  assign wr     = lpc_en & lpc_io_wren;
  assign rd     = lpc_en & lpc_io_rden;
  assign off    = index - IDX_BASE;
  assign in_win = (off[7:2] == 6'd0);

  assign post_lvl = wr & post_cs;
  assign winw_lvl = wr & data_cs & in_win;
  assign winr_lvl = rd & data_cs & (off == 8'd0);

  // One event per LPC cycle no matter how long the strobe is held
  assign post_wr    = post_lvl & ~post_lvl_q;
  assign win_wr     = winw_lvl & ~winw_lvl_q;
  assign win_rd_end = winr_lvl_q & ~winr_lvl;

  assign empty   = (count_q == '0);
  assign full    = (count_q == cnt_t'(DEPTH));
  assign accept  = post_wr & ~(DEDUP && (din == cur_q));
  assign stat_wr = win_wr & (off[1:0] == 2'd2);
  assign flush   = stat_wr & din[7];
  assign ovf_clr = stat_wr & din[2];
  assign pop     = win_rd_end & ~empty;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    cur_d   = cur_q;
    seen_d  = seen_q;
    stall_d = stall_q;
    if (accept) begin
      cur_d  = din;
      seen_d = 1'b1;
    end
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (ovf_clr) ovf_d = 1'b0;
      // Pop retires the old head before a same-cycle push lands
      if (pop) begin
        rptr_d  = rptr_d + 1'b1;
        count_d = count_d - 1'b1;
      end
      if (accept) begin
        wptr_d = wptr_q + 1'b1;
        if (count_d == cnt_t'(DEPTH)) begin
          rptr_d = rptr_d + 1'b1;
          ovf_d  = 1'b1;
        end else begin
          count_d = count_d + 1'b1;
        end
      end
    end
    if (accept)
      stall_d = '0;
    else if (stall_q != STALL_CYCLES)
      stall_d = stall_q + 24'd1;
  end

  always_ff @(posedge LPC_CLK or negedge LPC_RSTn) begin
    if (!LPC_RSTn) begin
      post_lvl_q <= 1'b0;
      winw_lvl_q <= 1'b0;
      winr_lvl_q <= 1'b0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      cur_q      <= 8'hFF;
      seen_q     <= 1'b0;
      stall_q    <= '0;
    end else begin
      post_lvl_q <= post_lvl;
      winw_lvl_q <= winw_lvl;
      winr_lvl_q <= winr_lvl;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      cur_q      <= cur_d;
      seen_q     <= seen_d;
      stall_q    <= stall_d;
    end
  end

  always_ff @(posedge LPC_CLK) begin
    if (accept) mem_q[wptr_q] <= din;
  end

  assign dout_en      = in_win & data_cs;
  assign postcode_cur = cur_q;
  assign log_count    = count_q;
  assign overflow     = ovf_q;
  assign stalled      = seen_q & (stall_q == STALL_CYCLES);

  always_comb begin
    dout = 8'h00;
    if (dout_en) begin
      unique case (off[1:0])
        2'd0: dout = empty ? 8'hFF : mem_q[rptr_q];
        2'd1: dout = 8'(count_q);
        2'd2: dout = {4'h0, stalled, ovf_q, full, empty};
        2'd3: dout = cur_q;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_postcode_log.sv
// Bench for lpc_postcode_log: vector table, corner sequences,
// then random traffic against a queue-based reference model.
module tb_lpc_postcode_log;

  localparam logic [7:0] B = 8'hC0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lpc_en, wren, rden, post_cs, data_cs;
  logic [7:0] index, din, dout, postcode_cur;
  logic       dout_en, overflow, stalled;
  logic [4:0] log_count;

  int vecs = 0;
  int errs = 0;

  lpc_postcode_log #(
    .DEPTH_LOG2(4), .IDX_BASE(B), .DEDUP(1'b1),
    .STALL_CYCLES(24'd100)
  ) dut (
    .LPC_CLK(clk), .LPC_RSTn(rst_n), .lpc_en(lpc_en),
    .lpc_io_wren(wren), .lpc_io_rden(rden),
    .post_cs(post_cs), .data_cs(data_cs), .index(index),
    .din(din), .dout(dout), .dout_en(dout_en),
    .postcode_cur(postcode_cur), .log_count(log_count),
    .overflow(overflow), .stalled(stalled)
  );

  always #5 clk = ~clk;

  typedef enum int {OP_POST, OP_RD, OP_WR} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] idx;
    logic [7:0] dat;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  logic       m_ovf;

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic idle_bus();
    lpc_en = 0; wren = 0; rden = 0;
    post_cs = 0; data_cs = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic post(input logic [7:0] code, input int len);
    @(negedge clk);
    lpc_en = 1; post_cs = 1; wren = 1; din = code;
    cycles(len);
    idle_bus();
    @(negedge clk);
  endtask

  task automatic win_rd(input logic [7:0] idx, output logic [7:0] d,
                        output logic en);
    @(negedge clk);
    lpc_en = 1; data_cs = 1; rden = 1; index = idx;
    @(negedge clk);
    d = dout; en = dout_en;
    @(negedge clk);
    idle_bus();
    @(negedge clk);
  endtask

  task automatic win_wr(input logic [7:0] idx, input logic [7:0] d);
    @(negedge clk);
    lpc_en = 1; data_cs = 1; wren = 1; index = idx; din = d;
    cycles(2);
    idle_bus();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_bus();
    index = 0; din = 0;
    rst_n = 0;
    cycles(3);
    rst_n = 1;
    cycles(2);
  endtask

  task automatic m_push(input logic [7:0] c);
    if (c != m_cur) begin
      m_cur = c;
      if (m_q.size() == 16) begin
        void'(m_q.pop_front());
        m_ovf = 1;
      end
      m_q.push_back(c);
    end
  endtask

  logic [7:0] rd_d, stv;
  logic       rd_en;

  initial begin
    rst_n = 1;
    do_reset();
    check("rst_cur", postcode_cur, 8'hFF);
    check("rst_cnt", 8'(log_count), 8'h00);
    check("rst_ovf_stall", {6'd0, overflow, stalled}, 8'h00);
    check("idle_dout", {dout[7:1], dout[0] | dout_en}, 8'h00);

    tbl.push_back('{OP_RD, B+2, 0, 8'h01});
    tbl.push_back('{OP_RD, B+3, 0, 8'hFF});
    tbl.push_back('{OP_RD, B+0, 0, 8'hFF});
    tbl.push_back('{OP_RD, B+1, 0, 8'h00});
    tbl.push_back('{OP_POST, 0, 8'h10, 0});
    tbl.push_back('{OP_POST, 0, 8'h20, 0});
    tbl.push_back('{OP_POST, 0, 8'h30, 0});
    tbl.push_back('{OP_RD, B+1, 0, 8'h03});
    tbl.push_back('{OP_RD, B+0, 0, 8'h10});
    tbl.push_back('{OP_RD, B+0, 0, 8'h20});
    tbl.push_back('{OP_RD, B+0, 0, 8'h30});
    tbl.push_back('{OP_RD, B+0, 0, 8'hFF});
    tbl.push_back('{OP_RD, B+1, 0, 8'h00});
    tbl.push_back('{OP_POST, 0, 8'h55, 0});
    tbl.push_back('{OP_POST, 0, 8'h55, 0});
    tbl.push_back('{OP_POST, 0, 8'h56, 0});
    tbl.push_back('{OP_RD, B+1, 0, 8'h02});
    tbl.push_back('{OP_RD, B+3, 0, 8'h56});
    tbl.push_back('{OP_WR, B+0, 8'h99, 0});
    tbl.push_back('{OP_RD, B+0, 0, 8'h55});
    tbl.push_back('{OP_RD, B+0, 0, 8'h56});
    tbl.push_back('{OP_RD, B+1, 0, 8'h00});

    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_POST: post(tbl[i].dat, 3);
        OP_WR:   win_wr(tbl[i].idx, tbl[i].dat);
        default: begin
          win_rd(tbl[i].idx, rd_d, rd_en);
          check($sformatf("tbl%0d", i), rd_d, tbl[i].exp);
          check($sformatf("tbl%0d_en", i), {7'd0, rd_en}, 8'h01);
        end
      endcase
    end

    // overflow, clear, flush
    for (int c = 1; c <= 18; c++) post(8'(c), 2);
    win_rd(B+1, rd_d, rd_en); check("ovf_cnt", rd_d, 8'h10);
    win_rd(B+2, rd_d, rd_en); check("ovf_stat", rd_d, 8'h06);
    win_rd(B+0, rd_d, rd_en); check("ovf_head", rd_d, 8'h03);
    win_wr(B+2, 8'h04);
    win_rd(B+2, rd_d, rd_en); check("ovf_clr", rd_d, 8'h00);
    win_wr(B+2, 8'h80);
    win_rd(B+1, rd_d, rd_en); check("flush_cnt", rd_d, 8'h00);
    win_rd(B+3, rd_d, rd_en); check("flush_last", rd_d, 8'h12);

    // stall detection
    post(8'hA0, 2);
    cycles(50);
    check("stall_early", {7'd0, stalled}, 8'h00);
    cycles(60);
    check("stall_set", {7'd0, stalled}, 8'h01);
    win_rd(B+2, rd_d, rd_en); check("stall_stat", rd_d, 8'h08);
    @(negedge clk);
    lpc_en = 1; post_cs = 1; wren = 1; din = 8'hA1;
    @(negedge clk);
    check("stall_clr", {7'd0, stalled}, 8'h00);
    check("stall_cur", postcode_cur, 8'hA1);
    idle_bus();

    // push and flush in one cycle
    @(negedge clk);
    lpc_en = 1; wren = 1; post_cs = 1; data_cs = 1;
    index = B+2; din = 8'h80;
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    check("pf_cnt", 8'(log_count), 8'h00);
    check("pf_cur", postcode_cur, 8'h80);

    // push and pop together on a full log
    for (int c = 0; c < 16; c++) post(8'h40 + 8'(c), 1);
    check("pp_full", 8'(log_count), 8'h10);
    @(negedge clk);
    lpc_en = 1; rden = 1; data_cs = 1; index = B;
    @(negedge clk);
    check("pp_head", dout, 8'h40);
    rden = 0; data_cs = 0; wren = 1; post_cs = 1; din = 8'h50;
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    check("pp_cnt", 8'(log_count), 8'h10);
    check("pp_ovf", {7'd0, overflow}, 8'h00);
    win_rd(B+0, rd_d, rd_en); check("pp_next", rd_d, 8'h41);

    // reset in the middle of a POST write
    @(negedge clk);
    lpc_en = 1; post_cs = 1; wren = 1; din = 8'h77;
    cycles(2);
    rst_n = 0;
    @(negedge clk);
    idle_bus();
    @(negedge clk);
    rst_n = 1;
    cycles(3);
    check("rstx_cnt", 8'(log_count), 8'h00);
    check("rstx_cur", postcode_cur, 8'hFF);
    win_rd(B+2, rd_d, rd_en); check("rstx_stat", rd_d, 8'h01);

    // random traffic against the queue model
    m_q.delete();
    m_cur = 8'hFF;
    m_ovf = 0;
    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 50) begin
        logic [7:0] c;
        c = 8'h60 + 8'($urandom_range(0, 7));
        post(c, int'($urandom_range(1, 3)));
        m_push(c);
        check("r_cur", postcode_cur, m_cur);
        check("r_cnt", 8'(log_count), 8'(m_q.size()));
      end else if (sel < 75) begin
        win_rd(B+0, rd_d, rd_en);
        if (m_q.size() == 0) check("r_data", rd_d, 8'hFF);
        else check("r_data", rd_d, m_q.pop_front());
      end else if (sel < 90) begin
        win_rd(B+2, rd_d, rd_en);
        stv = {5'd0, m_ovf, m_q.size() == 16, m_q.size() == 0};
        check("r_stat", rd_d & 8'hF7, stv);
        check("r_ovf", {7'd0, overflow}, {7'd0, m_ovf});
      end else begin
        logic [7:0] w;
        w = 8'($urandom()) & 8'h7F;
        if ($urandom_range(0, 3) == 0) w[7] = 1'b1;
        win_wr(B+2, w);
        if (w[7]) begin
          m_q.delete();
          m_ovf = 0;
        end else if (w[2]) m_ovf = 0;
        check("r_swr_cnt", 8'(log_count), 8'(m_q.size()));
      end
    end
    win_rd(B+3, rd_d, rd_en);
    check("r_last", rd_d, m_cur);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/lpc_postcode_log.md
Name: lpc_postcode_log

Overview:
- Downstream consumer of the port-0x80 POST write path on the LPC bus.
- Captures every BIOS POST code written to port 0x80 into a circular history FIFO.
- Tracks the current code and flags a boot stall when no new code arrives for a programmable time.
- Firmware or a debug tool reads the history back through the 0xA80/0xA81 index/data window. The current code also feeds the front-panel LED mux.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries)
IDX_BASE, 8'hC0, first index of the 4-register window
DEDUP, 1, 1 = drop a write equal to the last accepted code
STALL_CYCLES, 24'd16_500_000, LPC_CLK cycles without a new code before stall asserts (0.5 s at 33 MHz)

Ports:
LPC_CLK  in  1  LPC clock, 33 MHz
LPC_RSTn  in  1  reset, asynchronous, active-low
lpc_en  in  1  LPC transaction active/valid from the LPC peripheral
lpc_io_wren  in  1  I/O write strobe (level, may span several cycles)
lpc_io_rden  in  1  I/O read strobe (level, may span several cycles)
post_cs  in  1  address hit on 0x080
data_cs  in  1  address hit on 0xA81 (data port)
index  in  8  current index register value
din  in  8  host write data
dout  out  8  read data for the index window
dout_en  out  1  high when index is in the window and data_cs is set; the top level muxes dout onto the LPC read bus only when this is high
postcode_cur  out  8  last accepted POST code
log_count  out  DEPTH_LOG2+1  entries held
overflow  out  1  sticky: an entry was overwritten
stalled  out  1  no new code for STALL_CYCLES

Behaviour:
- Reset values: all outputs 0, except postcode_cur = 8'hFF. FIFO pointers 0; stall counter 0.
- Event detection:
  - wr_q = lpc_en & lpc_io_wren. rd_q = lpc_en & lpc_io_rden.
  - Each has a 1-cycle registered copy.
  - post_wr event = rising edge of (wr_q & post_cs): exactly one event per LPC cycle regardless of strobe length.
  - win_wr = rising edge of (wr_q & data_cs & index in window).
  - win_rd_end = falling edge of (rd_q & data_cs & index == IDX_BASE).
- Push, on post_wr:
  - If DEDUP = 1 and din == postcode_cur, drop the code: no push, and the stall counter is not cleared.
  - Otherwise postcode_cur <= din, write at wptr, wptr++ (wraps mod depth).
  - If the FIFO is not full, count++.
  - If the FIFO is full, rptr++ (oldest entry discarded), count unchanged, overflow <= 1.
  - Effects are visible the cycle after the edge.
- Window registers (index relative to IDX_BASE):
  - +0 LOG_DATA, RO: returns the oldest entry, or 8'hFF when empty.
    - The pop happens on win_rd_end, so data stays stable for the whole read cycle.
    - Pop on empty: no effect.
  - +1 LOG_COUNT, RO: zero-extended count.
  - +2 STATUS:
    - Read: bit0 empty, bit1 full, bit2 overflow, bit3 stalled, bits[7:4] = 0.
    - Write: bit2 = 1 clears overflow; bit7 = 1 flushes (pointers, count, overflow <= 0; postcode_cur unchanged). Other bits are ignored.
  - +3 LAST, RO: postcode_cur.
  - Writes to the RO registers are ignored.
- dout is combinational from the current state and index. dout = 8'h00 when dout_en = 0.
- Simultaneous events in one cycle:
  - Push and pop: the pop removes the old head first, then the push applies. Count is unchanged; overflow is not set even if the FIFO was full.
  - Push and flush: the flush wins, and the pushed code still updates postcode_cur.
  - Push and overflow-clear: the overflow set wins.
- Stall counter:
  - Cleared on every accepted push.
  - Otherwise increments, saturating at STALL_CYCLES.
  - stalled = (counter == STALL_CYCLES) and count-or-postcode_cur seen since reset, i.e. at least one code accepted since reset.
  - stalled deasserts the cycle after the next accepted push.
- Reset asserted mid-transaction: all state returns to reset values immediately. Any edge in flight is discarded, with the edge registers reset to 0, so no spurious event occurs on release.

Test Plan:
- Reset, then read STATUS -> 8'h01 (empty). LAST -> 8'hFF. LOG_DATA -> 8'hFF. postcode_cur = 8'hFF.
- Write 0x10, 0x20, 0x30 to 0x80, each with a 3-cycle wren -> count = 3. Three LOG_DATA reads return 0x10, 0x20, 0x30, then 0xFF. Count = 0.
- DEDUP = 1: write 0x55, 0x55, 0x56 -> count = 2, entries 0x55, 0x56.
- Write 18 distinct codes 0x01..0x12 -> count = 16, STATUS = 8'h06 (full + overflow). First read returns 0x03. Write STATUS 0x04 -> overflow = 0. Write STATUS 0x80 -> count = 0, LAST still 0x12.
- STALL_CYCLES = 100: write 0xA0 and idle 100 cycles -> stalled = 1, STATUS bit3 = 1. Write 0xA1 -> stalled = 0 the next cycle.
- Assert LPC_RSTn low during a 0x80 write with wren still high, then release -> no entry logged, count = 0, postcode_cur = 0xFF.
